// File: rtl/spi_ram_ctrl_if.sv
// Signal bundle shared by the SPI pins, the controller and the single-port SPI RAM.
// The slave modport is the controller's view; the master modport is the view of the pins and RAM.
interface spi_ram_ctrl_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 ss_n;
    logic                 mosi;
    logic                 miso;
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    modport slave (
        input  ss_n, mosi, tx_data, tx_valid,
        output miso, rx_data, rx_valid
    );

    modport master (
        output ss_n, mosi, tx_data, tx_valid,
        input  miso, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// SPI slave sequencer for the single-port SPI RAM: deserialises command words onto rx_data
// and serialises read bytes on miso. Define SPI_RAM_CTRL_CMD_CHECK_EN to reject inconsistent commands.
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst,
    spi_ram_ctrl_if.slave bus
);
    localparam int         CMD_W        = ADDR_SIZE + 2;
    localparam logic [3:0] PAYLOAD_LAST = 4'(CMD_W - 1);
    localparam logic [3:0] BYTE_LAST    = 4'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, DRAIN} state_t;
    typedef enum logic [1:0] {RD_PAYLOAD, RD_WAIT, RD_SHIFT} rd_phase_t;

    state_t               r_state;
    rd_phase_t            r_rd_phase;
    logic [3:0]           r_bit_cnt;
    logic [CMD_W-2:0]     r_shift;
    logic [CMD_W-1:0]     r_rx_data;
    logic                 r_rx_valid;
    logic [ADDR_SIZE-2:0] r_tx_shift;
    logic                 r_miso;
    logic                 r_rd_addr_flag;

    state_t               w_state_next;
    logic [CMD_W-1:0]     w_payload;
    logic                 w_done;
    logic                 w_cmd_ok;
    logic                 w_strobe;
    logic                 w_fin_byte;

    assign w_payload = {r_shift, bus.mosi};

`ifdef SPI_RAM_CTRL_CMD_CHECK_EN
    // The state already encodes the type bit: WRITE means type 0, READ_* means type 1.
    always_comb begin
        w_cmd_ok = 1'b0;
        case (r_state)
            WRITE:     w_cmd_ok = (w_payload[CMD_W-1] == 1'b0);
            READ_ADD:  w_cmd_ok = (w_payload[CMD_W-1:CMD_W-2] == 2'b10);
            READ_DATA: w_cmd_ok = (w_payload[CMD_W-1:CMD_W-2] == 2'b11);
            default:   w_cmd_ok = 1'b0;
        endcase
    end
`else
    assign w_cmd_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that leaves one unassigned infers a latch.
        w_state_next = r_state;
        w_done       = 1'b0;
        w_fin_byte   = 1'b0;
        if (bus.ss_n) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = CHK_CMD;
                CHK_CMD: begin
                    if (!bus.mosi)          w_state_next = WRITE;
                    else if (r_rd_addr_flag) w_state_next = READ_DATA;
                    else                     w_state_next = READ_ADD;
                end
                WRITE, READ_ADD: begin
                    if (r_bit_cnt == PAYLOAD_LAST) begin
                        w_done       = 1'b1;
                        w_state_next = DRAIN;
                    end
                end
                READ_DATA: begin
                    case (r_rd_phase)
                        RD_PAYLOAD: begin
                            if (r_bit_cnt == PAYLOAD_LAST) begin
                                w_done = 1'b1;
                                if (!w_cmd_ok) w_state_next = DRAIN;
                            end
                        end
                        RD_SHIFT: begin
                            if (r_bit_cnt == BYTE_LAST) begin
                                w_fin_byte   = 1'b1;
                                w_state_next = DRAIN;
                            end
                        end
                        default: w_state_next = r_state;
                    endcase
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    assign w_strobe = w_done & w_cmd_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_phase     <= RD_PAYLOAD;
            r_bit_cnt      <= '0;
            r_shift        <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_tx_shift     <= '0;
            r_miso         <= 1'b0;
            r_rd_addr_flag <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            r_rx_valid <= w_strobe;
            if (w_strobe) r_rx_data <= w_payload;

            if (w_strobe && (r_state == READ_ADD)) r_rd_addr_flag <= 1'b1;
            else if (w_fin_byte)                   r_rd_addr_flag <= 1'b0;

            if (bus.ss_n || !(r_state inside {WRITE, READ_ADD, READ_DATA})) begin
                r_bit_cnt  <= '0;
                r_miso     <= 1'b0;
                r_rd_phase <= RD_PAYLOAD;
            end else if ((r_state == READ_DATA) && (r_rd_phase == RD_WAIT)) begin
                if (bus.tx_valid) begin
                    r_miso     <= bus.tx_data[ADDR_SIZE-1];
                    r_tx_shift <= bus.tx_data[ADDR_SIZE-2:0];
                    r_bit_cnt  <= '0;
                    r_rd_phase <= RD_SHIFT;
                end
            end else if ((r_state == READ_DATA) && (r_rd_phase == RD_SHIFT)) begin
                if (r_bit_cnt == BYTE_LAST) begin
                    r_miso     <= 1'b0;
                    r_bit_cnt  <= '0;
                    r_rd_phase <= RD_PAYLOAD;
                end else begin
                    r_miso     <= r_tx_shift[ADDR_SIZE-2];
                    r_tx_shift <= {r_tx_shift[ADDR_SIZE-3:0], 1'b0};
                    r_bit_cnt  <= r_bit_cnt + 4'd1;
                end
            end else begin
                r_shift <= w_payload[CMD_W-2:0];
                if (w_done) begin
                    r_bit_cnt <= '0;
                    if (w_state_next == READ_DATA) r_rd_phase <= RD_WAIT;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    assign bus.miso     = r_miso;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: write, read, abort, reset and command-check frames.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spi_ram_ctrl;
    localparam int ADDR_SIZE = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks      = 0;
    int   failures    = 0;
    int   strobe_cnt  = 0;
    int   exp_strobes = 0;
    logic [7:0] byte_exp;

    spi_ram_ctrl_if #(.ADDR_SIZE(ADDR_SIZE)) bus ();

    spi_ram_ctrl #(.ADDR_SIZE(ADDR_SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rx_valid === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drives ss_n low, the type bit, then nbits payload bits MSB first; ss_n is left low.
    task automatic frame(input logic typ, input logic [9:0] pl, input int nbits);
        bus.ss_n = 1'b0;
        tick();
        bus.mosi = typ;
        tick();
        for (int i = 9; i > 9 - nbits; i--) begin
            bus.mosi = pl[i];
            tick();
        end
    endtask

    task automatic end_frame();
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        bus.ss_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        tick();
        tick();
        check("reset_miso",     16'(bus.miso),            16'h0);
        check("reset_rx_valid", 16'(bus.rx_valid),        16'h0);
        check("reset_rx_data",  16'(bus.rx_data),         16'h0);
        check("reset_flag",     16'(dut.r_rd_addr_flag),  16'h0);
        rst = 1'b0;
        tick();

        // Write address with strobe timing and trailing MOSI bits
        frame(1'b0, 10'h0A5, 9);
        check("wa_no_early_strobe", 16'(bus.rx_valid), 16'h0);
        bus.mosi = 1'b1;
        tick();
        check("wa_strobe",  16'(bus.rx_valid), 16'h1);
        check("wa_rx_data", 16'(bus.rx_data),  16'h0A5);
        for (int i = 0; i < 5; i++) begin
            bus.mosi = i[0];
            tick();
        end
        check("wa_one_cycle", 16'(bus.rx_valid), 16'h0);
        end_frame();
        exp_strobes = 1;
        check("wa_strobe_count", 16'(strobe_cnt),   16'(exp_strobes));
        check("wa_rx_data_hold", 16'(bus.rx_data),  16'h0A5);

        // Write data with tx_valid held high, which must be ignored
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        frame(1'b0, 10'h13C, 10);
        check("wd_strobe",  16'(bus.rx_valid), 16'h1);
        check("wd_rx_data", 16'(bus.rx_data),  16'h13C);
        check("wd_miso",    16'(bus.miso),     16'h0);
        tick();
        check("wd_miso_late", 16'(bus.miso), 16'h0);
        bus.tx_valid = 1'b0;
        end_frame();
        exp_strobes = 2;
        check("wd_strobe_count", 16'(strobe_cnt),  16'(exp_strobes));
        check("wd_rx_data_hold", 16'(bus.rx_data), 16'h13C);

        // Read address then read data returning 8'h3C
        frame(1'b1, 10'h207, 10);
        check("ra_strobe",  16'(bus.rx_valid),       16'h1);
        check("ra_rx_data", 16'(bus.rx_data),        16'h207);
        check("ra_flag",    16'(dut.r_rd_addr_flag), 16'h1);
        end_frame();
        frame(1'b1, 10'h300, 10);
        check("rd_strobe",  16'(bus.rx_valid), 16'h1);
        check("rd_rx_data", 16'(bus.rx_data),  16'h300);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h3C;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        check("rd_flag_during_byte", 16'(dut.r_rd_addr_flag), 16'h1);
        byte_exp = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            check($sformatf("rd_miso_bit%0d", i), 16'(bus.miso), 16'(byte_exp[i]));
            tick();
        end
        check("rd_drain_miso", 16'(bus.miso),            16'h0);
        check("rd_flag_clear", 16'(dut.r_rd_addr_flag),  16'h0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        tick();
        check("rd_drain_ignores_tx", 16'(bus.miso), 16'h0);
        bus.tx_valid = 1'b0;
        end_frame();
        exp_strobes = 4;
        check("rd_strobe_count", 16'(strobe_cnt), 16'(exp_strobes));

        // Abort after 5 payload bits, then a clean frame
        frame(1'b0, 10'h3FF, 5);
        end_frame();
        check("abort5_no_strobe", 16'(strobe_cnt),  16'(exp_strobes));
        check("abort5_rx_hold",   16'(bus.rx_data), 16'h300);
        frame(1'b0, 10'h155, 10);
        check("post_abort_strobe",  16'(bus.rx_valid), 16'h1);
        check("post_abort_rx_data", 16'(bus.rx_data),  16'h155);
        end_frame();
        exp_strobes = 5;

        // ss_n rises on the same edge as the 10th payload bit
        frame(1'b0, 10'h0F0, 9);
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        tick();
        check("abort10_no_strobe", 16'(bus.rx_valid), 16'h0);
        tick();
        check("abort10_count",   16'(strobe_cnt),  16'(exp_strobes));
        check("abort10_rx_hold", 16'(bus.rx_data), 16'h155);

        // Reset during miso bit 3
        frame(1'b1, 10'h207, 10);
        end_frame();
        frame(1'b1, 10'h300, 10);
        check("rst_rd_rx_data", 16'(bus.rx_data), 16'h300);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h3C;
        tick();
        bus.tx_valid = 1'b0;
        for (int i = 7; i >= 3; i--) begin
            check($sformatf("rst_miso_bit%0d", i), 16'(bus.miso), 16'(byte_exp[i]));
            if (i != 3) tick();
        end
        rst      = 1'b1;
        bus.ss_n = 1'b1;
        bus.mosi = 1'b0;
        #1;
        check("rst_async_miso",    16'(bus.miso),           16'h0);
        check("rst_async_flag",    16'(dut.r_rd_addr_flag), 16'h0);
        check("rst_async_rx_data", 16'(bus.rx_data),        16'h0);
        tick();
        rst = 1'b0;
        tick();
        exp_strobes = 7;
        check("rst_strobe_count", 16'(strobe_cnt), 16'(exp_strobes));
        frame(1'b1, 10'h2AB, 10);
        check("post_rst_strobe",   16'(bus.rx_valid),       16'h1);
        check("post_rst_rx_data",  16'(bus.rx_data),        16'h2AB);
        check("post_rst_read_add", 16'(dut.r_rd_addr_flag), 16'h1);
        end_frame();
        exp_strobes = 8;

        // Write frame whose payload carries a read command
        frame(1'b0, 10'h2FF, 10);
`ifdef SPI_RAM_CTRL_CMD_CHECK_EN
        check("cc_no_strobe", 16'(bus.rx_valid), 16'h0);
        for (int i = 0; i < 12; i++) begin
            bus.mosi = ~i[0];
            tick();
        end
        check("cc_drain_no_strobe", 16'(bus.rx_valid),       16'h0);
        check("cc_flag_kept",       16'(dut.r_rd_addr_flag), 16'h1);
        end_frame();
        check("cc_rx_hold", 16'(bus.rx_data), 16'h2AB);
`else
        check("cc_strobe",  16'(bus.rx_valid), 16'h1);
        check("cc_rx_data", 16'(bus.rx_data),  16'h2FF);
        end_frame();
        exp_strobes++;
`endif
        check("cc_strobe_count", 16'(strobe_cnt), 16'(exp_strobes));

        frame(1'b0, 10'h0FF, 10);
        check("final_strobe",  16'(bus.rx_valid), 16'h1);
        check("final_rx_data", 16'(bus.rx_data),  16'h0FF);
        end_frame();
        exp_strobes++;
        check("final_strobe_count", 16'(strobe_cnt), 16'(exp_strobes));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
